// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a 32x32 asynchronous-read RAM.
// Orders address/data setup, a WE pulse of ACC_CYC cycles and a hold cycle, then returns a response.
module mem_access_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int ACC_CYC = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_dir,
  output logic [DATA_W-1:0] ram_dato,
  input  logic [DATA_W-1:0] ram_q,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [3:0] ACC_LAST = 4'(ACC_CYC - 1);

  state_t              state_q;
  logic                op_we_q;
  logic [3:0]          acc_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_we_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_dir_q;
  logic [DATA_W-1:0]   ram_dato_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [CNT_W-1:0]    wr_cnt_q;

  // Sequencer FSM; every output is a register, and reset kills ram_we without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_we_q     <= 1'b0;
      acc_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_dir_q   <= '0;
      ram_dato_q  <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            op_we_q     <= req_we;
            ram_dir_q   <= req_addr;
            ram_dato_q  <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= ADDR;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ADDR: begin
          ram_we_q <= op_we_q;
          acc_q    <= ACC_LAST;
          state_q  <= ACCESS;
        end
        ACCESS: begin
          if (acc_q == 4'd0) begin
            // Q has had the whole access window to settle on the stable address.
            ram_we_q    <= 1'b0;
            rsp_we_q    <= op_we_q;
            rsp_rdata_q <= op_we_q ? '0 : ram_q;
            state_q     <= HOLD;
          end else begin
            acc_q <= acc_q - 4'd1;
          end
        end
        HOLD: begin
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
            if (op_we_q) begin
              wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end else begin
              rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          ram_we_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_dir   = ram_dir_q;
  assign ram_dato  = ram_dato_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule
